// File: rtl/led_arbiter.sv
// ---------------------------------------------------------------------------
// led_arbiter
//
// Decides who drives the four board LEDs. Three owners compete for the LEDs:
//   - the heartbeat chaser (background, shown whenever nobody else owns them)
//   - a status requester (shows a latched pattern for a fixed dwell time)
//   - a fault source (highest priority, blinks the fault code)
// All timing is counted in display ticks, produced by an internal prescaler
// that divides clk by TICK_DIV.
//
// Parameters:
//   TICK_DIV    clk cycles per display tick (2 .. 2^24)
//   HOLD_TICKS  ticks a status pattern stays on the LEDs (1 .. 255)
//   BLINK_TICKS ticks per half-period of the fault blink (1 .. 255)
//
// Ports:
//   clk         the only clock, rising edge
//   reset       asynchronous, active-high reset
//   hb_pattern  background heartbeat pattern
//   st_req      status request level, held until st_ack
//   st_pattern  status pattern, valid while st_req is high
//   st_ack      one-cycle pulse when a status request is accepted
//   fault       fault level, overrides everything
//   fault_code  pattern blinked while fault is high
//   led         registered LED drive
//   mode        current owner: 00 IDLE, 01 SHOW, 10 FAULT
// ---------------------------------------------------------------------------
module led_arbiter #(
  parameter int TICK_DIV    = 1000000,
  parameter int HOLD_TICKS  = 8,
  parameter int BLINK_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hb_pattern,
  input  logic       st_req,
  input  logic [3:0] st_pattern,
  output logic       st_ack,
  input  logic       fault,
  input  logic [3:0] fault_code,
  output logic [3:0] led,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHOW  = 2'b01,
    FAULT = 2'b10
  } state_t;

  localparam logic [23:0] PRESC_RELOAD = 24'(TICK_DIV - 1);
  localparam logic [7:0]  HOLD_LOAD    = 8'(HOLD_TICKS);
  localparam logic [7:0]  BLINK_LOAD   = 8'(BLINK_TICKS);

  state_t      state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  blink_q, blink_d;
  logic        phase_q, phase_d;
  logic [3:0]  pat_q, pat_d;
  logic [3:0]  led_q, led_d;
  logic        ack_q, ack_d;
  logic        tick;

  // A tick is the single cycle in which the prescaler sits at zero.
  assign tick = (presc_q == '0);

  // Next-state logic. Fault always wins; a status request is only taken from
  // IDLE, so it simply waits (still held by the requester) while SHOW or
  // FAULT own the LEDs.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    blink_d = blink_q;
    phase_d = phase_q;
    pat_d   = pat_q;
    ack_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (fault) begin
          state_d = FAULT;
          phase_d = 1'b1;
          blink_d = BLINK_LOAD;
        end else if (st_req) begin
          state_d = SHOW;
          pat_d   = st_pattern;
          hold_d  = HOLD_LOAD;
          ack_d   = 1'b1;
        end
      end

      SHOW: begin
        if (fault) begin
          // The status display is dropped for good; it is not resumed later.
          state_d = FAULT;
          phase_d = 1'b1;
          blink_d = BLINK_LOAD;
          hold_d  = '0;
        end else if (tick) begin
          if (hold_q <= 8'd1) begin
            state_d = IDLE;
            hold_d  = '0;
          end else begin
            hold_d = hold_q - 8'd1;
          end
        end
      end

      FAULT: begin
        if (!fault) begin
          state_d = IDLE;
          phase_d = 1'b0;
          blink_d = '0;
        end else if (tick) begin
          if (blink_q <= 8'd1) begin
            phase_d = ~phase_q;
            blink_d = BLINK_LOAD;
          end else begin
            blink_d = blink_q - 8'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Prescaler restarts on every ownership change so that each dwell time is
  // an exact number of full ticks measured from the moment of entry.
  always_comb begin
    presc_d = presc_q - 24'd1;
    if ((state_d != state_q) || tick) begin
      presc_d = PRESC_RELOAD;
    end
  end

  // LED value is chosen from the state being entered, so led and mode always
  // change on the same edge and led never depends combinationally on inputs.
  always_comb begin
    led_d = 4'b0000;
    case (state_d)
      IDLE:    led_d = hb_pattern;
      SHOW:    led_d = pat_d;
      FAULT:   led_d = phase_d ? fault_code : 4'b0000;
      default: led_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= PRESC_RELOAD;
      hold_q  <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      pat_q   <= '0;
      led_q   <= 4'b0000;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      pat_q   <= pat_d;
      led_q   <= led_d;
      ack_q   <= ack_d;
    end
  end

  assign led    = led_q;
  assign mode   = state_q;
  assign st_ack = ack_q;

endmodule

// File: tb/tb_led_arbiter.sv
// ---------------------------------------------------------------------------
// tb_led_arbiter
//
// Scoreboard bench for led_arbiter with TICK_DIV=4, HOLD_TICKS=3,
// BLINK_TICKS=2. The stimulus process drives inputs on falling edges and
// pushes the hand-computed {led, mode, st_ack} expected after a given rising
// edge count. A monitor process pops entries when their cycle arrives and
// compares. Mid-cycle checks (asynchronous reset) are pushed with cycle -1
// and fire the monitor through an event.
// ---------------------------------------------------------------------------
module tb_led_arbiter;

  typedef struct packed {
    int         cyc;
    logic [3:0] led;
    logic [1:0] mode;
    logic       ack;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] hb_pattern;
  logic       st_req;
  logic [3:0] st_pattern;
  logic       st_ack;
  logic       fault;
  logic [3:0] fault_code;
  logic [3:0] led;
  logic [1:0] mode;

  int    cyc;
  int    n_vec;
  int    n_miss;
  int    base;
  int    base2;
  bit    flush;
  exp_t  exp_q[$];
  string name_q[$];
  exp_t  cur_e;
  string cur_n;
  event  imm_ev;

  led_arbiter #(
    .TICK_DIV   (4),
    .HOLD_TICKS (3),
    .BLINK_TICKS(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .hb_pattern(hb_pattern),
    .st_req    (st_req),
    .st_pattern(st_pattern),
    .st_ack    (st_ack),
    .fault     (fault),
    .fault_code(fault_code),
    .led       (led),
    .mode      (mode)
  );

  // Free-running clock, period 10; rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count of rising edges seen so far; expected entries are tagged with it.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: immediate entries first, then stale entries, then due entries.
  always @(negedge clk or imm_ev) begin
    while (exp_q.size() > 0 && exp_q[0].cyc == -1) begin
      cur_e = exp_q.pop_front();
      cur_n = name_q.pop_front();
      n_vec++;
      if (led !== cur_e.led || mode !== cur_e.mode || st_ack !== cur_e.ack) begin
        n_miss++;
        $display("[TB] FAIL %s: got led=%b mode=%b ack=%b, want led=%b mode=%b ack=%b",
                 cur_n, led, mode, st_ack, cur_e.led, cur_e.mode, cur_e.ack);
      end
    end
    while (exp_q.size() > 0 && (flush || exp_q[0].cyc < cyc)) begin
      cur_e = exp_q.pop_front();
      cur_n = name_q.pop_front();
      n_vec++;
      n_miss++;
      $display("[TB] FAIL %s: entry for cycle %0d never compared (now %0d)",
               cur_n, cur_e.cyc, cyc);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      cur_e = exp_q.pop_front();
      cur_n = name_q.pop_front();
      n_vec++;
      if (led !== cur_e.led || mode !== cur_e.mode || st_ack !== cur_e.ack) begin
        n_miss++;
        $display("[TB] FAIL %s@%0d: got led=%b mode=%b ack=%b, want led=%b mode=%b ack=%b",
                 cur_n, cyc, led, mode, st_ack, cur_e.led, cur_e.mode, cur_e.ack);
      end
    end
  end

  // Queue an expectation for the outputs seen after rising edge c.
  task automatic pushExpect(input int c, input logic [3:0] l, input logic [1:0] m,
                            input logic a, input string nm);
    exp_t e;
    e.cyc  = c;
    e.led  = l;
    e.mode = m;
    e.ack  = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Compare right now, between clock edges.
  task automatic checkOutput(input string nm, input logic [3:0] l, input logic [1:0] m,
                             input logic a);
    pushExpect(-1, l, m, a, nm);
    -> imm_ev;
    #0;
  endtask

  task automatic applyStimulus(input logic req, input logic [3:0] pat, input logic flt,
                               input logic [3:0] code, input logic [3:0] hb);
    st_req     = req;
    st_pattern = pat;
    fault      = flt;
    fault_code = code;
    hb_pattern = hb;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    flush  = 1'b0;
    reset  = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0101);

    // Reset and heartbeat follow
    repeat (3) @(negedge clk);
    checkOutput("reset_hold", 4'b0000, 2'b00, 1'b0);
    reset = 1'b0;
    base  = cyc;
    pushExpect(base + 1, 4'b0101, 2'b00, 1'b0, "post_reset");
    pushExpect(base + 2, 4'b0101, 2'b00, 1'b0, "idle_hb");
    repeat (2) @(negedge clk);

    // Status display: 12-cycle dwell, st_pattern changes ignored
    @(negedge clk);
    base = cyc;
    applyStimulus(1'b1, 4'b1010, 1'b0, 4'b0000, 4'b0101);
    pushExpect(base + 1, 4'b1010, 2'b01, 1'b1, "show_ack");
    for (int k = 2; k <= 12; k++) pushExpect(base + k, 4'b1010, 2'b01, 1'b0, "show_hold");
    pushExpect(base + 13, 4'b0110, 2'b00, 1'b0, "show_end");
    pushExpect(base + 14, 4'b0110, 2'b00, 1'b0, "idle_after_show");
    @(negedge clk);
    applyStimulus(1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0110);
    repeat (13) @(negedge clk);
    applyStimulus(1'b0, 4'b0011, 1'b0, 4'b0000, 4'b1001);
    pushExpect(base + 15, 4'b1001, 2'b00, 1'b0, "idle_follow");
    @(negedge clk);

    // Fault at cycle 5 of a SHOW, blink 8 on / 8 off, live fault_code
    @(negedge clk);
    base = cyc;
    applyStimulus(1'b1, 4'b1100, 1'b0, 4'b0000, 4'b1001);
    pushExpect(base + 1, 4'b1100, 2'b01, 1'b1, "show2_ack");
    for (int k = 2; k <= 5; k++) pushExpect(base + k, 4'b1100, 2'b01, 1'b0, "show2_hold");
    for (int k = 6; k <= 13; k++) pushExpect(base + k, 4'b1111, 2'b10, 1'b0, "blink_on");
    for (int k = 14; k <= 21; k++) pushExpect(base + k, 4'b0000, 2'b10, 1'b0, "blink_off");
    pushExpect(base + 22, 4'b1111, 2'b10, 1'b0, "blink_on2");
    pushExpect(base + 23, 4'b1001, 2'b10, 1'b0, "blink_live_code");
    pushExpect(base + 24, 4'b1001, 2'b00, 1'b0, "fault_exit");
    pushExpect(base + 25, 4'b1001, 2'b00, 1'b0, "no_reshow");
    @(negedge clk);
    applyStimulus(1'b0, 4'b1100, 1'b0, 4'b0000, 4'b1001);
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 4'b1100, 1'b1, 4'b1111, 4'b1001);
    repeat (17) @(negedge clk);
    applyStimulus(1'b0, 4'b1100, 1'b1, 4'b1001, 4'b1001);
    @(negedge clk);
    applyStimulus(1'b0, 4'b1100, 1'b0, 4'b1001, 4'b1001);
    repeat (2) @(negedge clk);

    // Fault and request together: fault wins, request served afterwards
    @(negedge clk);
    base = cyc;
    applyStimulus(1'b1, 4'b1110, 1'b1, 4'b0101, 4'b0010);
    for (int k = 1; k <= 3; k++) pushExpect(base + k, 4'b0101, 2'b10, 1'b0, "fault_beats_req");
    pushExpect(base + 4, 4'b0010, 2'b00, 1'b0, "idle_before_ack");
    pushExpect(base + 5, 4'b1110, 2'b01, 1'b1, "deferred_ack");
    pushExpect(base + 6, 4'b1110, 2'b01, 1'b0, "ack_single");
    pushExpect(base + 7, 4'b1110, 2'b01, 1'b0, "show3_hold");
    for (int k = 8; k <= 10; k++) pushExpect(base + k, 4'b1011, 2'b10, 1'b0, "fault2_on");
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 4'b1110, 1'b0, 4'b0101, 4'b0010);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 4'b1110, 1'b0, 4'b0101, 4'b0010);
    repeat (2) @(negedge clk);
    applyStimulus(1'b0, 4'b1110, 1'b1, 4'b1011, 4'b0010);
    repeat (3) @(negedge clk);

    // Asynchronous reset between edges in FAULT
    #2;
    reset = 1'b1;
    fault = 1'b0;
    #1;
    checkOutput("async_reset", 4'b0000, 2'b00, 1'b0);
    @(negedge clk);
    checkOutput("reset_held", 4'b0000, 2'b00, 1'b0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0100);
    reset = 1'b0;
    base2 = cyc;
    pushExpect(base2 + 1, 4'b0100, 2'b00, 1'b0, "first_edge_idle");
    pushExpect(base2 + 2, 4'b0100, 2'b00, 1'b0, "no_stale_ack");
    pushExpect(base2 + 3, 4'b0001, 2'b01, 1'b1, "fresh_req_ack");
    pushExpect(base2 + 4, 4'b0001, 2'b01, 1'b0, "fresh_req_single");
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 4'b0001, 1'b0, 4'b0000, 4'b0100);
    @(negedge clk);
    applyStimulus(1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0100);

    // Drain the scoreboard with a bounded wait; leftovers count as failures
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    flush = 1'b1;
    -> imm_ev;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/led_arbiter.md
LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000: clk cycles per display tick, legal range 2..2^24.
REQ-002 SHALL have parameter HOLD_TICKS, default 8: ticks a status pattern is displayed, legal range 1..255.
REQ-003 SHALL have parameter BLINK_TICKS, default 2: ticks per fault-blink half-period, legal range 1..255.
REQ-004 SHALL have port clk  input  1  the only clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port hb_pattern  input  4  background heartbeat pattern from the LED chaser.
REQ-007 SHALL have port st_req  input  1  status-display request, level, held by requester until st_ack.
REQ-008 SHALL have port st_pattern  input  4  status pattern, valid while st_req=1.
REQ-009 SHALL have port st_ack  output  1  one-cycle pulse, status request accepted.
REQ-010 SHALL have port fault  input  1  fault level, highest priority.
REQ-011 SHALL have port fault_code  input  4  pattern blinked while fault=1.
REQ-012 SHALL have port led  output  4  registered LED drive.
REQ-013 SHALL have port mode  output  2  current owner: 00 IDLE, 01 SHOW, 10 FAULT.

Function
REQ-014 SHALL implement states IDLE, SHOW, FAULT; mode SHALL equal the state encoding, registered.
REQ-015 SHALL run a prescaler counting down from TICK_DIV-1 to 0; tick SHALL be one cycle when the count is 0, then reload TICK_DIV-1.
REQ-016 SHALL reload the prescaler to TICK_DIV-1 on every state transition, so durations are exact multiples of TICK_DIV.
REQ-017 IDLE: led SHALL follow hb_pattern with one cycle of latency.
REQ-018 IDLE, fault=0, st_req=1: SHALL latch st_pattern, pulse st_ack for exactly one cycle, load hold counter with HOLD_TICKS, enter SHOW.
REQ-019 SHOW: led SHALL show the latched pattern; st_pattern changes SHALL be ignored.
REQ-020 SHOW: hold counter SHALL decrement on each tick; tick at count 1 SHALL enter IDLE, giving a SHOW dwell of exactly HOLD_TICKS*TICK_DIV cycles.
REQ-021 st_req in SHOW or FAULT SHALL NOT be acknowledged; it SHALL be served on the first IDLE cycle where fault=0.
REQ-022 fault=1 in any state SHALL enter FAULT on the next edge; a SHOW in progress SHALL be abandoned without re-display.
REQ-023 fault=1 and st_req=1 together in IDLE: fault SHALL win; st_ack SHALL stay 0.
REQ-024 FAULT entry SHALL set blink phase=1 and load blink counter with BLINK_TICKS.
REQ-025 FAULT: led SHALL be fault_code (live) when phase=1, 4'b0000 when phase=0.
REQ-026 FAULT: blink counter SHALL decrement per tick; at count 1 it SHALL toggle phase and reload BLINK_TICKS.
REQ-027 FAULT with fault=0 SHALL enter IDLE on the next edge, regardless of blink phase.
REQ-028 led SHALL change only on a clock edge; led SHALL never be driven from combinational input paths.
REQ-029 st_ack SHALL never be high on two consecutive cycles.

Reset
REQ-030 reset=1 SHALL immediately, without a clock, force state IDLE, led=4'b0000, st_ack=0, mode=00, prescaler=TICK_DIV-1, hold and blink counters=0, phase=0.
REQ-031 reset asserted mid-SHOW or mid-FAULT SHALL discard the latched pattern and counters; no st_ack SHALL follow deassertion unless st_req is still high.
REQ-032 The first edge after reset deassertion SHALL be evaluated as IDLE.

Verification (TICK_DIV=4, HOLD_TICKS=3, BLINK_TICKS=2)
REQ-033 Reset, hb_pattern=4'b0101 -> led=0000 during reset, 0101 one cycle after deassertion, mode=00.
REQ-034 st_req=1, st_pattern=4'b1010 in IDLE -> st_ack one cycle, led=1010, mode=01 for exactly 12 cycles, then led follows hb_pattern.
REQ-035 fault=1 with fault_code=4'b1111 at cycle 5 of SHOW -> mode=10; led 1111 for 8 cycles, 0000 for 8 cycles, repeating; no second st_ack.
REQ-036 fault=1 and st_req=1 on the same IDLE cycle -> mode=10, st_ack=0; after fault drops, st_ack pulses on the first IDLE cycle.
REQ-037 reset pulsed asynchronously mid-FAULT between clock edges -> led=0000 and mode=00 before the next edge.
